// File: rtl/color_unpremultiplier_pkg.sv
// color_unpremultiplier_pkg: shared sub-pixel indices and width-derived constants
package color_unpremultiplier_pkg;
  localparam int W = 8;
  localparam int ALPHA_IDX = 0;
  localparam int B_IDX = 1;
  localparam int G_IDX = 2;
  localparam int R_IDX = 3;
  localparam int MAX = (1 << W) - 1;
  localparam int ITER = W;
endpackage

// File: rtl/color_channel_divider.sv
// color_channel_divider: restoring divider producing q = floor(c * 2^W / a), saturating
// Ports: aclk/reset clock and async reset; start latches c and a (flags set here);
// step shifts one quotient bit in, MSB first; q is the result (0 if a==0, max if c>=a).
module color_channel_divider #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  input  logic [W-1:0] c,
  input  logic [W-1:0] a,
  output logic [W-1:0] q
);
  logic [W:0] r;
  logic [W:0] r2;
  logic [W-1:0] qr;
  logic sat;
  logic zero;
  logic take;
  assign r2 = r << 1;
  assign take = r2 >= {1'b0, a};
  always_ff @(posedge aclk or posedge reset)
    if (reset) begin
      r <= '0;
      qr <= '0;
      sat <= 1'b0;
      zero <= 1'b0;
    end else if (start) begin
      r <= {1'b0, c};
      qr <= '0;
      zero <= a == '0;
      sat <= a != '0 && c >= a;
    end else if (step) begin
      r <= take ? r2 - {1'b0, a} : r2;
      qr <= {qr[W-2:0], take};
    end
  // flagged channels still iterate; their raw quotient is simply overridden here
  assign q = zero ? '0 : sat ? '1 : qr;
endmodule

// File: rtl/color_unpremultiplier.sv
// color_unpremultiplier: divides each RGB sub-pixel by alpha, rescaled to full range
// Ports: aclk/reset clock and async active-high reset; s_valid/s_ready/s_pixel input
// handshake (premultiplied RGBA, alpha in sub-pixel 0); m_valid/m_ready/m_pixel output
// handshake (un-premultiplied RGBA, alpha passed through).
module color_unpremultiplier
  import color_unpremultiplier_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = W
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [4*SUB_PIXEL_WIDTH-1:0] s_pixel,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [4*SUB_PIXEL_WIDTH-1:0] m_pixel
);
  localparam int SW = SUB_PIXEL_WIDTH;
  localparam int PIXEL_WIDTH = 4 * SW;
  localparam int CW = $clog2(SW + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] alpha;
  logic [SW-1:0] dvsr;
  logic start;
  logic step;
  assign s_ready = state == IDLE && !reset;
  assign m_valid = state == DONE;
  assign start = s_valid && s_ready;
  assign step = state == DIVIDE;
  // flags are computed on the accept edge, before alpha is registered
  assign dvsr = start ? s_pixel[ALPHA_IDX*SW +: SW] : alpha;
  always_ff @(posedge aclk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      alpha <= '0;
    end else begin
      if (start) alpha <= s_pixel[ALPHA_IDX*SW +: SW];
      state <= state == IDLE ? (start ? DIVIDE : IDLE) :
               state == DIVIDE ? (cnt == '0 ? DONE : DIVIDE) :
               (m_ready ? IDLE : DONE);
      cnt <= start ? CW'(SW - 1) : (step && cnt != '0) ? cnt - 1'b1 : cnt;
    end
  for (genvar i = B_IDX; i <= R_IDX; i++) begin : g_ch
    color_channel_divider #(.W(SW)) u_div (
      .aclk (aclk),
      .reset(reset),
      .start(start),
      .step (step),
      .c    (s_pixel[i*SW +: SW]),
      .a    (dvsr),
      .q    (m_pixel[i*SW +: SW])
    );
  end
  assign m_pixel[ALPHA_IDX*SW +: SW] = alpha;
  if (PIXEL_WIDTH != 4 * SW) begin : g_bad_width
    $error("pixel width must be four sub-pixels");
  end
endmodule

// File: tb/tb_color_unpremultiplier.sv
// tb_color_unpremultiplier: vector, random and corner-case checks against a reference model
module tb_color_unpremultiplier;
  logic aclk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [31:0] s_pixel = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [31:0] m_pixel;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] px;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[4];
  logic [31:0] exp_q[$];
  int acc[$];
  color_unpremultiplier #(.SUB_PIXEL_WIDTH(8)) dut (
    .aclk   (aclk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_pixel(s_pixel),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_pixel(m_pixel)
  );
  always #5 aclk = ~aclk;
  function automatic logic [7:0] ref_ch(int c, int a);
    if (a == 0) return 8'd0;
    if (c >= a) return 8'd255;
    return 8'((c * 256) / a);
  endfunction
  function automatic logic [31:0] ref_px(logic [31:0] p);
    return {ref_ch(int'(p[31:24]), int'(p[7:0])), ref_ch(int'(p[23:16]), int'(p[7:0])),
            ref_ch(int'(p[15:8]), int'(p[7:0])), p[7:0]};
  endfunction
  function automatic logic [7:0] rand_color(int a);
    int c;
    c = ($urandom % 4 == 0) ? a + int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 255));
    return 8'(c < 0 ? 0 : c > 255 ? 255 : c);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_pixel(input logic [31:0] px, input logic [31:0] exp, input int stall);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("ready_before_send", 32'(s_ready), 32'd1);
    s_pixel = px;
    s_valid = 1'b1;
    @(negedge aclk);
    s_valid = 1'b0;
    s_pixel = $urandom;
    n = 1;
    while (!m_valid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("latency", 32'(n), 32'd9);
    check("result", m_pixel, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      s_pixel = $urandom;
      check("stall_pixel", m_pixel, exp);
      check("stall_flags", {30'd0, m_valid, s_ready}, 32'b10);
    end
    m_ready = 1'b1;
    check("done_ready_low", 32'(s_ready), 32'd0);
    @(negedge aclk);
    m_ready = 1'b0;
    check("after_handshake", {30'd0, m_valid, s_ready}, 32'b01);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] px;
    int a;
    vecs[0] = '{32'h40_64_01_80, 32'h80_C8_02_80};
    vecs[1] = '{32'hFE_01_00_FF, 32'hFE_01_00_FF};
    vecs[2] = '{32'hC8_64_63_64, 32'hFF_FF_FD_64};
    vecs[3] = '{32'hFF_FF_FF_00, 32'h00_00_00_00};
    #12;
    check("reset_outputs", {s_ready, m_valid, 30'd0}, 32'd0);
    check("reset_pixel", m_pixel, 32'd0);
    @(negedge aclk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(s_ready), 32'd1);
    @(negedge aclk);
    for (int i = 0; i < 4; i++) run_pixel(vecs[i].px, vecs[i].exp, i % 2);
    run_pixel(vecs[0].px, vecs[0].exp, 5);
    for (int i = 0; i < 30; i++) begin
      a = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 255));
      px = {rand_color(a), rand_color(a), rand_color(a), 8'(a)};
      run_pixel(px, ref_px(px), int'($urandom_range(0, 3)));
    end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge aclk);
      if (m_valid) begin
        if (exp_q.size() == 0) check("b2b_extra", m_pixel, 32'hxxxx_xxxx);
        else check("b2b_pixel", m_pixel, exp_q.pop_front());
      end
      s_valid = 1'b0;
      if (s_ready && acc.size() < 5) begin
        px = $urandom;
        s_pixel = px;
        s_valid = 1'b1;
        exp_q.push_back(ref_px(px));
        acc.push_back(cyc);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("b2b_count", 32'(acc.size()), 32'd5);
    check("b2b_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < acc.size(); i++) check("b2b_period", 32'(acc[i] - acc[i-1]), 32'd10);
    @(negedge aclk);
    s_pixel = vecs[1].px;
    s_valid = 1'b1;
    @(negedge aclk);
    s_valid = 1'b0;
    repeat (3) @(negedge aclk);
    reset = 1'b1;
    #1;
    check("abort_outputs", {s_ready, m_valid, 30'd0}, 32'd0);
    check("abort_pixel", m_pixel, 32'd0);
    @(negedge aclk);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(s_ready), 32'd1);
    @(negedge aclk);
    run_pixel(vecs[2].px, vecs[2].exp, 0);
    run_pixel(32'h10_20_30_40, ref_px(32'h10_20_30_40), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
